// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bundle between EX/MEM and the data memory.
// DMEM_BYTE_STROBE_EN adds byte_en for per-lane stores.
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]  byte_en;
`endif
    logic        resp_valid;
    logic [31:0] read_data;
    logic        inv_addr;
    logic        stall;

    modport master (
        output req_valid, mem_read, mem_write, address, write_data,
`ifdef DMEM_BYTE_STROBE_EN
        output byte_en,
`endif
        input  req_ready, resp_valid, read_data, inv_addr, stall
    );

    modport slave (
        input  req_valid, mem_read, mem_write, address, write_data,
`ifdef DMEM_BYTE_STROBE_EN
        input  byte_en,
`endif
        output req_ready, resp_valid, read_data, inv_addr, stall
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle word RAM controller for the MEM stage.
// DMEM_BYTE_STROBE_EN enables per-byte store lanes via byte_en.
module data_mem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          accept;
    logic          bad_req;
    logic          mem_we;
    logic          stall_q;

    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic          is_store;
    logic          is_bad;
`ifdef DMEM_BYTE_STROBE_EN
    logic [3:0]    be_q;
`endif

    logic [31:0]   rdata;
    logic          bad_flag;
    logic [31:0]   mem [DEPTH];

    assign accept  = (state == IDLE) && bus.req_valid
                   && (bus.mem_read || bus.mem_write);
    assign bad_req = (bus.address[1:0] != 2'b00)
                   || (bus.address[31:2] >= 30'(DEPTH))
                   || (bus.mem_read && bus.mem_write);

    // Next state: BUSY counts down so RESP is entered LATENCY edges after accept
    always_comb begin
        state_next = state;
        count_next = count;
        mem_we     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                    count_next = CW'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (count == '0) begin
                    state_next = RESP;
                    mem_we     = is_store && !is_bad;
                end else begin
                    count_next = count - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, countdown and registered stall
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            stall_q <= (state_next != IDLE);
        end
    end

    // Capture the request so later input changes cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            wdata    <= '0;
            is_store <= 1'b0;
            is_bad   <= 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
            be_q     <= '0;
`endif
        end else if (accept) begin
            idx      <= bus.address[AW+1:2];
            wdata    <= bus.write_data;
            is_store <= bus.mem_write;
            is_bad   <= bad_req;
`ifdef DMEM_BYTE_STROBE_EN
            be_q     <= bus.byte_en;
`endif
        end
    end

    // Response data and error flag, loaded on the edge entering RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata    <= '0;
            bad_flag <= 1'b0;
        end else if (state == BUSY && count == '0) begin
            bad_flag <= is_bad;
            rdata    <= (is_bad || is_store) ? 32'h0 : mem[idx];
        end
    end

    // RAM write port; contents survive reset but a reset edge blocks the write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
`ifdef DMEM_BYTE_STROBE_EN
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
`else
            mem[idx] <= wdata;
`endif
        end
    end

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = (state == RESP);
    assign bus.read_data  = rdata;
    assign bus.inv_addr   = bad_flag;
    assign bus.stall      = stall_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random transactions against a word-array model.
// Build with DMEM_BYTE_STROBE_EN to exercise byte lanes; LAT may be overridden.
module tb_data_mem_ctrl #(
    parameter int LAT = 2
);
    localparam int DEPTH = 256;
    localparam int NW    = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] ref_mem [NW];

    data_mem_ctrl_if bus ();

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = $urandom;
        bus.write_data = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
        bus.byte_en    = 4'($urandom);
`endif
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        bus.req_valid  = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.address    = addr;
        bus.write_data = wd;
`ifdef DMEM_BYTE_STROBE_EN
        bus.byte_en    = be;
`else
        if (be == 4'hx) bus.write_data = wd;
`endif
    endtask

    // Full transaction from an idle negedge; model computes the outcome
    task automatic xact(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
        logic [29:0] w;
        bit          bad;
        logic [31:0] exp_d;
        logic [31:0] m;
        int          n;
        logic        s;
        logic        r;
        w     = addr[31:2];
        bad   = (addr[1:0] != 2'b00) || (w >= 30'(DEPTH)) || (rd && wr);
        exp_d = 32'h0;
        if (!bad && rd) exp_d = ref_mem[w[3:0]];
        if (!bad && wr) begin
            m = ref_mem[w[3:0]];
            for (int i = 0; i < 4; i++) begin
`ifdef DMEM_BYTE_STROBE_EN
                if (be[i]) m[8*i +: 8] = wd[8*i +: 8];
`else
                m[8*i +: 8] = wd[8*i +: 8];
`endif
            end
            ref_mem[w[3:0]] = m;
        end
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        drive(rd, wr, addr, wd, be);
        n = 0;
        while (n < LAT + 8) begin
            @(negedge clk);
            n++;
            s = bus.stall;
            r = bus.resp_valid;
            if (n == 1) idle_bus();
            check("stall_busy", 32'(s), 32'd1);
            if (r) break;
        end
        check("latency", 32'(n), 32'(LAT + 1));
        check("read_data", bus.read_data, exp_d);
        check("inv_addr", 32'(bus.inv_addr), 32'(bad));
        @(negedge clk);
        check("resp_pulse", 32'(bus.resp_valid), 32'd0);
        check("stall_idle", 32'(bus.stall), 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int k;
        logic [31:0] a;
        rst = 1'b1;
        idle_bus();
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp", 32'(bus.resp_valid), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_rdata", bus.read_data, 32'd0);
        check("rst_inv", 32'(bus.inv_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NW; i++) begin
            ref_mem[i] = 32'h0;
            xact(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);
        end

        xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        check("deadbeef", ref_mem[4], 32'hDEADBEEF);
        xact(1'b1, 1'b0, 32'h12, 32'h0, 4'h0);
        xact(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        xact(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF);
        xact(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
        xact(1'b1, 1'b1, 32'h14, 32'h55555555, 4'hF);
        xact(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);

        // No op selected: ignored, no response
        drive(1'b0, 1'b0, 32'h10, 32'h1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noop_stall", 32'(bus.stall), 32'd0);
            check("noop_resp", 32'(bus.resp_valid), 32'd0);
        end
        idle_bus();

        // Reset one cycle after a store is accepted
        drive(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF);
        @(negedge clk);
        idle_bus();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd0);
        check("rst_mid_stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            check("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
        end
        xact(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);

        // Hold a load request through BUSY: back-to-back accepts only after RESP
        drive(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        t1 = 0;
        t2 = 0;
        for (int n = 1; n <= 4 * LAT + 12; n++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                check("hold_rdata", bus.read_data, ref_mem[4]);
                if (t1 == 0) t1 = n;
                else begin
                    t2 = n;
                    idle_bus();
                    break;
                end
            end
        end
        idle_bus();
        check("hold_first", 32'(t1), 32'(LAT + 1));
        check("hold_gap", 32'(t2 - t1), 32'(LAT + 2));
        @(negedge clk);
        check("hold_done", 32'(bus.stall), 32'd0);

`ifdef DMEM_BYTE_STROBE_EN
        xact(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF);
        xact(1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101);
        xact(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        check("strobe", ref_mem[2], 32'hAA22CC44);
        xact(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0);
        xact(1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
`endif

        for (int i = 0; i < 80; i++) begin
            k = $urandom_range(0, 9);
            a = {26'($urandom_range(0, NW - 1)), 2'b00} & 32'h3F;
            if (k == 7) a = a | 32'($urandom_range(1, 3));
            if (k >= 8) a = 32'((DEPTH + $urandom_range(0, 4000)) * 4);
            k = $urandom_range(0, 9);
            xact(k < 4 || k > 7, k >= 4, a, $urandom, 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
